// File: rtl/dma_copy_if.sv
// rtl/dma_copy_if.sv - memory request/response bus between dma_copy and a memory target
// Signals:
//   mem_valid  : request strobe, one cycle per request (initiator)
//   mem_instr  : instruction-fetch flag, always 0 from the DMA (initiator)
//   mem_addr   : word-aligned byte address (initiator)
//   mem_wdata  : write data (initiator)
//   mem_wstrb  : byte strobes, 4'hF for a write, 4'h0 for a read (initiator)
//   mem_rdata  : read data, valid with mem_ready (target)
//   mem_ready  : response strobe (target)
//   mem_error  : response carries an error, valid with mem_ready (target)
// Modports: master (DMA side), slave (memory side).
interface dma_copy_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready, mem_error
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready, mem_error
    );
endinterface

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - single-channel word copy DMA with optional fill mode
// Optional feature macro: DMA_FILL_EN (fill mode; absent = copy only, fill inputs ignored).
// Parameters:
//   cnt_width : width of count and the remaining-word register
//   timeout   : max cycles to wait for mem_ready (0 = wait forever)
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   start                   : one-cycle transfer request (honoured only when idle)
//   src_addr, dst_addr      : byte addresses, bits [1:0] are dropped
//   count                   : number of 32-bit words (0 = immediate done)
//   fill, fill_data         : fill-mode select and pattern, sampled with start
//   busy, done, err         : in-progress, one-cycle completion, sticky error
//   mem (dma_copy_if.master): memory request/response bus
module dma_copy #(
    parameter int cnt_width = 16,
    parameter int timeout   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [cnt_width-1:0] count,
    input  logic                 fill,
    input  logic [31:0]          fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    dma_copy_if.master           mem
);
    localparam int WAIT_W  = (timeout < 2) ? 1 : $clog2(timeout);
    localparam int TO_LAST = (timeout < 1) ? 0 : timeout - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state_q;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [cnt_width-1:0] remaining_q;
    logic [WAIT_W-1:0]    wait_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 valid_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 fill_mode;
    logic [31:0]          fill_word;
    logic                 wait_expired;
    logic                 unused_addr_bits;

`ifdef DMA_FILL_EN
    logic        fill_q;
    logic [31:0] fill_data_q;
    assign fill_mode = fill_q;
    assign fill_word = fill_data_q;
`else
    logic unused_fill;
    assign fill_mode   = 1'b0;
    assign fill_word   = 32'd0;
    assign unused_fill = &{1'b0, fill, fill_data};
`endif

    assign unused_addr_bits = &{1'b0, src_addr[1:0], dst_addr[1:0]};
    assign wait_expired     = (timeout != 0) && (wait_q == WAIT_W'(TO_LAST));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
`ifdef DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_data_q <= '0;
`endif
        end else begin
            // Request fields are registered and live only in the cycle after
            // the transition into a REQ state; everything else sees zeros.
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            src_q       <= {src_addr[31:2], 2'b00};
                            dst_q       <= {dst_addr[31:2], 2'b00};
                            remaining_q <= count;
                            err_q       <= 1'b0;
                            busy_q      <= 1'b1;
                            valid_q     <= 1'b1;
`ifdef DMA_FILL_EN
                            fill_q      <= fill;
                            fill_data_q <= fill_data;
                            if (fill) begin
                                state_q <= WR_REQ;
                                addr_q  <= {dst_addr[31:2], 2'b00};
                                wdata_q <= fill_data;
                                wstrb_q <= 4'hF;
                            end else begin
                                state_q <= RD_REQ;
                                addr_q  <= {src_addr[31:2], 2'b00};
                            end
`else
                            state_q <= RD_REQ;
                            addr_q  <= {src_addr[31:2], 2'b00};
`endif
                        end
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                    wait_q  <= '0;
                end
                WR_REQ: begin
                    state_q <= WR_WAIT;
                    wait_q  <= '0;
                end
                RD_WAIT: begin
                    if (mem.mem_ready) begin
                        if (mem.mem_error) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Read data goes straight into the write request.
                            state_q <= WR_REQ;
                            valid_q <= 1'b1;
                            addr_q  <= dst_q;
                            wdata_q <= mem.mem_rdata;
                            wstrb_q <= 4'hF;
                        end
                    end else if (wait_expired) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (mem.mem_ready) begin
                        if (mem.mem_error) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            src_q       <= src_q + 32'd4;
                            dst_q       <= dst_q + 32'd4;
                            remaining_q <= remaining_q - cnt_width'(1);
                            if (remaining_q == cnt_width'(1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else if (fill_mode) begin
                                state_q <= WR_REQ;
                                valid_q <= 1'b1;
                                addr_q  <= dst_q + 32'd4;
                                wdata_q <= fill_word;
                                wstrb_q <= 4'hF;
                            end else begin
                                state_q <= RD_REQ;
                                valid_q <= 1'b1;
                                addr_q  <= src_q + 32'd4;
                            end
                        end
                    end else if (wait_expired) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem.mem_valid = valid_q;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;
endmodule
